// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: request handshake, operands, result and flags.
// The slave modport is the ALU side; the master modport is the requester side.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic             i_Valid;
    logic             o_Ready;
    logic [3:0]       i_OpCtrl;
    logic             i_UpdateCondCodes;
    logic [WIDTH-1:0] i_LeftOp;
    logic [WIDTH-1:0] i_RightOp;
    logic [WIDTH-1:0] o_Result;
    logic             o_Valid;
    logic [3:0]       o_ConditionCodes;
    logic             o_Illegal;

    modport slave (
        input  i_Valid,
        input  i_OpCtrl,
        input  i_UpdateCondCodes,
        input  i_LeftOp,
        input  i_RightOp,
        output o_Ready,
        output o_Result,
        output o_Valid,
        output o_ConditionCodes,
        output o_Illegal
    );

    modport master (
        output i_Valid,
        output i_OpCtrl,
        output i_UpdateCondCodes,
        output i_LeftOp,
        output i_RightOp,
        input  o_Ready,
        input  o_Result,
        input  o_Valid,
        input  o_ConditionCodes,
        input  o_Illegal
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops and an iterative shift-add multiplier.
// Condition codes are {C,Z,N,V}; all outputs are registered.
module seq_alu #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned MUL_EN = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    seq_alu_if.slave   bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MUL_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_ready;

    // Latched single-cycle operation, completed on the edge after acceptance
    logic               r_pend;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_left;
    logic [WIDTH-1:0]   r_right;
    logic               r_upd;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHW-1:0]     r_count;
    logic               r_mul_upd;

    logic [WIDTH-1:0]   r_result;
    logic               r_valid;
    logic               r_illegal;
    logic [3:0]         r_cc;

    logic               w_accept;
    logic               w_is_mul;
    logic [SHW-1:0]     w_amt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH:0]     w_asr;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_illegal;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_mul_lo;
    logic               w_mul_c;

    assign w_accept = bus.i_Valid && r_ready;
    assign w_is_mul = (MUL_EN != 0) && (bus.i_OpCtrl == 4'd9);

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_lo   = w_acc_next[WIDTH-1:0];
    assign w_mul_c    = |w_acc_next[2*WIDTH-1:WIDTH];

    // Shifts run in WIDTH+1 bits so the extra bit captures the last bit shifted out
    always_comb begin
        w_amt     = r_right[SHW-1:0];
        w_sum     = {1'b0, r_left} + {1'b0, r_right};
        w_diff    = {1'b0, r_left} - {1'b0, r_right};
        w_shl     = {1'b0, r_left} << w_amt;
        w_shr     = {r_left, 1'b0} >> w_amt;
        w_asr     = $signed({r_left, 1'b0}) >>> w_amt;
        w_res     = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_illegal = 1'b0;
        case (r_op)
            4'd0: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_left[WIDTH-1] == r_right[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != r_left[WIDTH-1]);
            end
            4'd1: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (r_left[WIDTH-1] != r_right[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != r_left[WIDTH-1]);
            end
            4'd2: w_res = r_left & r_right;
            4'd3: w_res = r_left | r_right;
            4'd4: w_res = r_left ^ r_right;
            4'd5: w_res = ~r_left;
            4'd6: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            4'd7: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            4'd8: begin
                w_res = w_asr[WIDTH:1];
                w_c   = w_asr[0];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Control, multiplier datapath and output registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_pend    <= 1'b0;
            r_op      <= '0;
            r_left    <= '0;
            r_right   <= '0;
            r_upd     <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_mul_upd <= 1'b0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_cc      <= '0;
        end else begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_pend    <= 1'b0;
            if (r_pend) begin
                r_result  <= w_res;
                r_valid   <= 1'b1;
                r_illegal <= w_illegal;
                if (r_upd && !w_illegal) begin
                    r_cc <= {w_c, (w_res == '0), w_res[WIDTH-1], w_v};
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state   <= S_MUL_BUSY;
                            r_ready   <= 1'b0;
                            r_acc     <= '0;
                            r_mcand   <= {WIDTH'(0), bus.i_LeftOp};
                            r_mplier  <= bus.i_RightOp;
                            r_count   <= '0;
                            r_mul_upd <= bus.i_UpdateCondCodes;
                        end else begin
                            r_pend    <= 1'b1;
                            r_op      <= bus.i_OpCtrl;
                            r_left    <= bus.i_LeftOp;
                            r_right   <= bus.i_RightOp;
                            r_upd     <= bus.i_UpdateCondCodes;
                        end
                    end
                end
                S_MUL_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + SHW'(1);
                    if (r_count == SHW'(WIDTH - 1)) begin
                        r_state  <= S_IDLE;
                        r_ready  <= 1'b1;
                        r_result <= w_mul_lo;
                        r_valid  <= 1'b1;
                        if (r_mul_upd) begin
                            r_cc <= {w_mul_c, (w_mul_lo == '0), w_mul_lo[WIDTH-1], 1'b0};
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_Ready          = r_ready;
    assign bus.o_Result         = r_result;
    assign bus.o_Valid          = r_valid;
    assign bus.o_Illegal        = r_illegal;
    assign bus.o_ConditionCodes = r_cc;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16, MUL_EN=1) with hand-computed expectations.
module tb_seq_alu;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(16)) bus();

    seq_alu #(.WIDTH(16), .MUL_EN(1)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus.slave)
    );

    task automatic drive(input logic [3:0] op, input logic [15:0] l, input logic [15:0] r,
                         input logic upd, input logic v);
        bus.i_OpCtrl          = op;
        bus.i_LeftOp          = l;
        bus.i_RightOp         = r;
        bus.i_UpdateCondCodes = upd;
        bus.i_Valid           = v;
    endtask

    // One-cycle request; returns at the falling edge after the accepting edge
    task automatic send(input logic [3:0] op, input logic [15:0] l, input logic [15:0] r,
                        input logic upd);
        @(negedge clk);
        drive(op, l, r, upd, 1'b1);
        @(negedge clk);
        bus.i_Valid = 1'b0;
    endtask

    task automatic test_reset();
        drive(4'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.o_Ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.o_Ready); end
        checks++; if (bus.o_Result !== 16'h0) begin failures++; $display("FAIL reset_result got=%h want=0000", bus.o_Result); end
        checks++; if (bus.o_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.o_Valid); end
        checks++; if (bus.o_Illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b want=0", bus.o_Illegal); end
        checks++; if (bus.o_ConditionCodes !== 4'b0000) begin failures++; $display("FAIL reset_cc got=%b want=0000", bus.o_ConditionCodes); end
        rst_n = 1'b1;
    endtask

    task automatic test_add_overflow();
        send(4'd0, 16'h7FFF, 16'h0001, 1'b1);
        checks++; if (bus.o_Valid !== 1'b0) begin failures++; $display("FAIL add_early_valid got=%b want=0", bus.o_Valid); end
        @(negedge clk);
        checks++; if (bus.o_Valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b want=1", bus.o_Valid); end
        checks++; if (bus.o_Result !== 16'h8000) begin failures++; $display("FAIL add_result got=%h want=8000", bus.o_Result); end
        checks++; if (bus.o_ConditionCodes !== 4'b0011) begin failures++; $display("FAIL add_cc got=%b want=0011", bus.o_ConditionCodes); end
        checks++; if (bus.o_Illegal !== 1'b0) begin failures++; $display("FAIL add_illegal got=%b want=0", bus.o_Illegal); end
    endtask

    task automatic test_sub_hold();
        send(4'd1, 16'h0000, 16'h0001, 1'b1);
        @(negedge clk);
        checks++; if (bus.o_Result !== 16'hFFFF) begin failures++; $display("FAIL sub_result got=%h want=ffff", bus.o_Result); end
        checks++; if (bus.o_ConditionCodes !== 4'b1010) begin failures++; $display("FAIL sub_cc got=%b want=1010", bus.o_ConditionCodes); end
        send(4'd0, 16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        checks++; if (bus.o_Result !== 16'h0002) begin failures++; $display("FAIL hold_result got=%h want=0002", bus.o_Result); end
        checks++; if (bus.o_ConditionCodes !== 4'b1010) begin failures++; $display("FAIL hold_cc got=%b want=1010", bus.o_ConditionCodes); end
    endtask

    task automatic test_logic();
        logic [3:0]  ops [4] = '{4'd2, 4'd3, 4'd4, 4'd5};
        logic [15:0] ls  [4] = '{16'hF0F0, 16'h8000, 16'hAAAA, 16'h00FF};
        logic [15:0] rs  [4] = '{16'h0FF0, 16'h0001, 16'hAAAA, 16'h1234};
        logic [15:0] ex  [4] = '{16'h00F0, 16'h8001, 16'h0000, 16'hFF00};
        logic [3:0]  ecc [4] = '{4'b0000, 4'b0010, 4'b0100, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            send(ops[i], ls[i], rs[i], 1'b1);
            @(negedge clk);
            checks++; if (bus.o_Result !== ex[i]) begin failures++; $display("FAIL logic_result[%0d] got=%h want=%h", i, bus.o_Result, ex[i]); end
            checks++; if (bus.o_ConditionCodes !== ecc[i]) begin failures++; $display("FAIL logic_cc[%0d] got=%b want=%b", i, bus.o_ConditionCodes, ecc[i]); end
        end
    endtask

    task automatic test_shift();
        logic [3:0]  ops [7] = '{4'd8, 4'd6, 4'd7, 4'd6, 4'd6, 4'd8, 4'd7};
        logic [15:0] ls  [7] = '{16'h8001, 16'h0001, 16'h0003, 16'h8000, 16'h0001, 16'h8000, 16'h8000};
        logic [15:0] rs  [7] = '{16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0011, 16'h000F, 16'h000F};
        logic [15:0] ex  [7] = '{16'hC000, 16'h0001, 16'h0001, 16'h0000, 16'h0002, 16'hFFFF, 16'h0001};
        logic [3:0]  ecc [7] = '{4'b1010, 4'b0000, 4'b1000, 4'b1100, 4'b0000, 4'b0010, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            send(ops[i], ls[i], rs[i], 1'b1);
            @(negedge clk);
            checks++; if (bus.o_Result !== ex[i]) begin failures++; $display("FAIL shift_result[%0d] got=%h want=%h", i, bus.o_Result, ex[i]); end
            checks++; if (bus.o_ConditionCodes !== ecc[i]) begin failures++; $display("FAIL shift_cc[%0d] got=%b want=%b", i, bus.o_ConditionCodes, ecc[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [3] = '{4'd0, 4'd1, 4'd4};
        logic [15:0] ls  [3] = '{16'h0001, 16'h0005, 16'hFFFF};
        logic [15:0] rs  [3] = '{16'h0002, 16'h0003, 16'h0F0F};
        logic [15:0] ex  [3] = '{16'h0003, 16'h0002, 16'hF0F0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++; if (bus.o_Valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b want=1", i - 2, bus.o_Valid); end
                checks++; if (bus.o_Result !== ex[i-2]) begin failures++; $display("FAIL b2b_result[%0d] got=%h want=%h", i - 2, bus.o_Result, ex[i-2]); end
            end
            if (i < 3) drive(ops[i], ls[i], rs[i], 1'b1, 1'b1);
            else bus.i_Valid = 1'b0;
        end
        checks++; if (bus.o_ConditionCodes !== 4'b0010) begin failures++; $display("FAIL b2b_cc got=%b want=0010", bus.o_ConditionCodes); end
        @(negedge clk);
        checks++; if (bus.o_Valid !== 1'b0) begin failures++; $display("FAIL b2b_tail_valid got=%b want=0", bus.o_Valid); end
    endtask

    task automatic test_mul_busy();
        logic exp_on;
        @(negedge clk);
        drive(4'd9, 16'h0100, 16'h0100, 1'b1, 1'b1);
        @(posedge clk);
        #1 drive(4'd0, 16'h0001, 16'h0001, 1'b1, 1'b1);
        for (int j = 0; j <= 16; j++) begin
            @(negedge clk);
            exp_on = (j == 16);
            checks++; if (bus.o_Ready !== exp_on) begin failures++; $display("FAIL mul_ready[%0d] got=%b want=%b", j, bus.o_Ready, exp_on); end
            checks++; if (bus.o_Valid !== exp_on) begin failures++; $display("FAIL mul_valid[%0d] got=%b want=%b", j, bus.o_Valid, exp_on); end
        end
        bus.i_Valid = 1'b0;
        checks++; if (bus.o_Result !== 16'h0000) begin failures++; $display("FAIL mul_result got=%h want=0000", bus.o_Result); end
        checks++; if (bus.o_ConditionCodes !== 4'b1100) begin failures++; $display("FAIL mul_cc got=%b want=1100", bus.o_ConditionCodes); end
        @(negedge clk);
        checks++; if (bus.o_Valid !== 1'b0) begin failures++; $display("FAIL mul_no_queue got=%b want=0", bus.o_Valid); end
        checks++; if (bus.o_ConditionCodes !== 4'b1100) begin failures++; $display("FAIL mul_cc_hold got=%b want=1100", bus.o_ConditionCodes); end
    endtask

    task automatic test_mul_values();
        logic [15:0] ls  [2] = '{16'h0123, 16'hFFFF};
        logic [15:0] rs  [2] = '{16'h0045, 16'hFFFF};
        logic [15:0] ex  [2] = '{16'h4E6F, 16'h0001};
        logic [3:0]  ecc [2] = '{4'b0000, 4'b1000};
        logic        seen;
        for (int i = 0; i < 2; i++) begin
            send(4'd9, ls[i], rs[i], 1'b1);
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                @(negedge clk);
                seen = bus.o_Valid;
            end
            checks++; if (seen !== 1'b1) begin failures++; $display("FAIL mulv_timeout[%0d] got=%b want=1", i, seen); end
            checks++; if (bus.o_Result !== ex[i]) begin failures++; $display("FAIL mulv_result[%0d] got=%h want=%h", i, bus.o_Result, ex[i]); end
            checks++; if (bus.o_ConditionCodes !== ecc[i]) begin failures++; $display("FAIL mulv_cc[%0d] got=%b want=%b", i, bus.o_ConditionCodes, ecc[i]); end
        end
    endtask

    task automatic test_illegal();
        send(4'd12, 16'h1234, 16'h5678, 1'b1);
        @(negedge clk);
        checks++; if (bus.o_Valid !== 1'b1) begin failures++; $display("FAIL ill_valid got=%b want=1", bus.o_Valid); end
        checks++; if (bus.o_Illegal !== 1'b1) begin failures++; $display("FAIL ill_pulse got=%b want=1", bus.o_Illegal); end
        checks++; if (bus.o_Result !== 16'h0000) begin failures++; $display("FAIL ill_result got=%h want=0000", bus.o_Result); end
        checks++; if (bus.o_ConditionCodes !== 4'b1000) begin failures++; $display("FAIL ill_cc got=%b want=1000", bus.o_ConditionCodes); end
        @(negedge clk);
        checks++; if (bus.o_Illegal !== 1'b0) begin failures++; $display("FAIL ill_pulse_end got=%b want=0", bus.o_Illegal); end
        send(4'd0, 16'h0001, 16'h0002, 1'b0);
        @(negedge clk);
        checks++; if (bus.o_Result !== 16'h0003) begin failures++; $display("FAIL ill_pre_result got=%h want=0003", bus.o_Result); end
        send(4'd15, 16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        checks++; if (bus.o_Result !== 16'h0000) begin failures++; $display("FAIL ill15_result got=%h want=0000", bus.o_Result); end
        checks++; if (bus.o_Illegal !== 1'b1) begin failures++; $display("FAIL ill15_pulse got=%b want=1", bus.o_Illegal); end
        checks++; if (bus.o_ConditionCodes !== 4'b1000) begin failures++; $display("FAIL ill15_cc got=%b want=1000", bus.o_ConditionCodes); end
    endtask

    task automatic test_reset_mul();
        logic stray;
        send(4'd1, 16'h0000, 16'h0001, 1'b1);
        @(negedge clk);
        checks++; if (bus.o_ConditionCodes !== 4'b1010) begin failures++; $display("FAIL rm_pre_cc got=%b want=1010", bus.o_ConditionCodes); end
        @(negedge clk);
        drive(4'd9, 16'h0003, 16'h0003, 1'b1, 1'b1);
        @(posedge clk);
        #1 bus.i_Valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_Ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b want=1", bus.o_Ready); end
        checks++; if (bus.o_ConditionCodes !== 4'b0000) begin failures++; $display("FAIL rm_cc got=%b want=0000", bus.o_ConditionCodes); end
        checks++; if (bus.o_Result !== 16'h0000) begin failures++; $display("FAIL rm_result got=%h want=0000", bus.o_Result); end
        checks++; if (bus.o_Valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b want=0", bus.o_Valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.o_Valid === 1'b1) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin failures++; $display("FAIL rm_stray_valid got=%b want=0", stray); end
        send(4'd0, 16'h0002, 16'h0002, 1'b1);
        @(negedge clk);
        checks++; if (bus.o_Valid !== 1'b1) begin failures++; $display("FAIL rm_after_valid got=%b want=1", bus.o_Valid); end
        checks++; if (bus.o_Result !== 16'h0004) begin failures++; $display("FAIL rm_after_result got=%h want=0004", bus.o_Result); end
        checks++; if (bus.o_ConditionCodes !== 4'b0000) begin failures++; $display("FAIL rm_after_cc got=%b want=0000", bus.o_ConditionCodes); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_hold();
        test_logic();
        test_shift();
        test_back_to_back();
        test_mul_busy();
        test_mul_values();
        test_illegal();
        test_reset_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
